// File: rtl/data_skewer_pkg.sv
// Shared types for the data_skewer block: controller state encoding.
package data_skewer_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FEED,
        S_DRAIN,
        S_DONE
    } skew_state_t;

endpackage

// File: rtl/skew_lane.sv
// One lane of the skew pipeline: DEPTH-stage data+valid shift register
// with a synchronous clear that empties every stage at once.
module skew_lane #(
    parameter int DEPTH     = 1,
    parameter int DATA_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clear,
    input  logic                 in_valid,
    input  logic [DATA_SIZE-1:0] in_data,
    output logic                 out_valid,
    output logic [DATA_SIZE-1:0] out_data
);

    logic [DEPTH-1:0]                valid_q;
    logic [DEPTH-1:0][DATA_SIZE-1:0] data_q;

    // NOTE: every stage is reset because the PEs consume zero-filled data;
    // an unreset stage would inject X into the array after power-up.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            data_q  <= '0;
        end else if (clear) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            valid_q[0] <= in_valid;
            data_q[0]  <= in_data;
            for (int s = 1; s < DEPTH; s++) begin
                valid_q[s] <= valid_q[s-1];
                data_q[s]  <= data_q[s-1];
            end
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/data_skewer.sv
// Staggers fetched rows onto a diagonal wavefront for the systolic array;
// lane i is delayed i+1 cycles, and a small FSM tracks one matrix's feed and drain.
module data_skewer
    import data_skewer_pkg::*;
#(
    parameter int MATRIX_SIZE = 2,
    parameter int DATA_SIZE   = 32,
    parameter int ROWS        = MATRIX_SIZE
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic                                  enable,
    input  logic                                  in_valid,
    input  logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] in_data,
    output logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] out_data,
    output logic [MATRIX_SIZE-1:0]                out_valid,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  overflow
);

    localparam int ROW_W   = $clog2(ROWS + 1);
    localparam int DRAIN_W = $clog2(MATRIX_SIZE + 1);
    localparam logic [ROW_W-1:0]   LAST_ROW   = ROW_W'(ROWS - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(MATRIX_SIZE - 1);

    skew_state_t          state, state_next;
    logic [ROW_W-1:0]     row_cnt, row_cnt_next;
    logic [DRAIN_W-1:0]   drain_cnt, drain_cnt_next;
    logic                 accept;
    logic                 drop;

    logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] lane_in;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            row_cnt   <= '0;
            drain_cnt <= '0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_next;
            row_cnt   <= row_cnt_next;
            drain_cnt <= drain_cnt_next;
            if (!enable)
                overflow <= 1'b0;
            else if (drop)
                overflow <= 1'b1;
        end
    end

    // NOTE: defaults first so every path assigns every output; no latches.
    always_comb begin
        state_next     = state;
        row_cnt_next   = row_cnt;
        drain_cnt_next = drain_cnt;
        accept         = 1'b0;
        drop           = 1'b0;
        if (!enable) begin
            state_next     = S_IDLE;
            row_cnt_next   = '0;
            drain_cnt_next = '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        accept         = 1'b1;
                        row_cnt_next   = ROW_W'(1);
                        drain_cnt_next = '0;
                        state_next     = (ROWS == 1) ? S_DRAIN : S_FEED;
                    end
                end
                S_FEED: begin
                    if (in_valid) begin
                        accept       = 1'b1;
                        row_cnt_next = row_cnt + ROW_W'(1);
                        if (row_cnt == LAST_ROW) begin
                            state_next     = S_DRAIN;
                            drain_cnt_next = '0;
                        end
                    end
                end
                S_DRAIN: begin
                    drop = in_valid;
                    if (drain_cnt == DRAIN_LAST)
                        state_next = S_DONE;
                    else
                        drain_cnt_next = drain_cnt + DRAIN_W'(1);
                end
                S_DONE: begin
                    drop = in_valid;
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    // Unaccepted cycles feed zeros so idle lanes stay zero-filled.
    assign lane_in = accept ? in_data : '0;

    for (genvar i = 0; i < MATRIX_SIZE; i++) begin : g_lane
        skew_lane #(
            .DEPTH    (i + 1),
            .DATA_SIZE(DATA_SIZE)
        ) u_lane (
            .clk      (clk),
            .reset_n  (reset_n),
            .clear    (!enable),
            .in_valid (accept),
            .in_data  (lane_in[i]),
            .out_valid(out_valid[i]),
            .out_data (out_data[i])
        );
    end

    assign busy = (state == S_FEED) || (state == S_DRAIN);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_data_skewer.sv
// Self-checking bench for data_skewer: randomized rows against a
// behavioural row-history model, plus directed ROWS==1 checks.
module tb_data_skewer;

    localparam int M    = 4;
    localparam int ROWS = 4;
    localparam int DW   = 16;
    localparam int BM   = 2;
    localparam int OW   = M*DW + M + 3;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b1;
    logic                 enable = 1'b0;
    logic                 in_valid = 1'b0;
    logic [M-1:0][DW-1:0] in_data = '0;
    logic [M-1:0][DW-1:0] out_data;
    logic [M-1:0]         out_valid;
    logic                 busy, done, overflow;

    logic                  b_enable = 1'b0;
    logic                  b_in_valid = 1'b0;
    logic [BM-1:0][DW-1:0] b_in_data = '0;
    logic [BM-1:0][DW-1:0] b_out_data;
    logic [BM-1:0]         b_out_valid;
    logic                  b_busy, b_done, b_overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_skewer #(.MATRIX_SIZE(M), .DATA_SIZE(DW), .ROWS(ROWS)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .in_valid(in_valid),
        .in_data(in_data), .out_data(out_data), .out_valid(out_valid),
        .busy(busy), .done(done), .overflow(overflow)
    );

    data_skewer #(.MATRIX_SIZE(BM), .DATA_SIZE(DW), .ROWS(1)) dut_r1 (
        .clk(clk), .reset_n(reset_n), .enable(b_enable), .in_valid(b_in_valid),
        .in_data(b_in_data), .out_data(b_out_data), .out_valid(b_out_valid),
        .busy(b_busy), .done(b_done), .overflow(b_overflow)
    );

    // Reference model: remembers what was accepted at each of the last M edges.
    // Lane i shows the row accepted i edges ago; completion is M edges after
    // the last row of the matrix.
    logic [M-1:0][DW-1:0] h_row [M];
    logic                 h_v   [M];
    int                   m_rows = 0;
    int                   m_last = 0;
    int                   m_cyc  = 0;
    logic                 m_ovf  = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < M; i++) begin
                h_v[i]   <= 1'b0;
                h_row[i] <= '0;
            end
            m_rows <= 0;
            m_ovf  <= 1'b0;
        end else begin
            m_cyc <= m_cyc + 1;
            if (!enable) begin
                for (int i = 0; i < M; i++) begin
                    h_v[i]   <= 1'b0;
                    h_row[i] <= '0;
                end
                m_rows <= 0;
                m_ovf  <= 1'b0;
            end else begin
                h_v[0]   <= in_valid && (m_rows < ROWS);
                h_row[0] <= (in_valid && (m_rows < ROWS)) ? in_data : '0;
                for (int i = 1; i < M; i++) begin
                    h_v[i]   <= h_v[i-1];
                    h_row[i] <= h_row[i-1];
                end
                if (in_valid && (m_rows < ROWS)) begin
                    m_rows <= m_rows + 1;
                    if (m_rows == ROWS - 1)
                        m_last <= m_cyc + 1;
                end
                if (in_valid && (m_rows == ROWS))
                    m_ovf <= 1'b1;
            end
        end
    end

    logic [M-1:0][DW-1:0] exp_data;
    logic [M-1:0]         exp_valid;
    logic                 exp_done, exp_busy;
    logic [OW-1:0]        obs, exp;

    always_comb begin
        exp_data  = '0;
        exp_valid = '0;
        for (int i = 0; i < M; i++) begin
            exp_valid[i] = h_v[i];
            exp_data[i]  = h_row[i][i];
        end
        exp_done = (m_rows == ROWS) && (m_cyc >= m_last + M);
        exp_busy = (m_rows > 0) && !exp_done;
    end

    assign obs = {out_data, out_valid, busy, done, overflow};
    assign exp = {exp_data, exp_valid, exp_busy, exp_done, m_ovf};

    task automatic drive(input bit v, input bit en);
        in_valid = v;
        enable   = en;
        for (int i = 0; i < M; i++) in_data[i] = DW'($urandom);
    endtask

    task automatic test_reset();
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL reset_initial got=%h exp=0", obs);
        end
        @(negedge clk);
        reset_n = 1'b1;
        drive(0, 1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL reset_load cyc=%0d got=%h exp=%h", m_cyc, obs, exp);
            end
            drive(1, 1);
        end
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL reset_midcycle got=%h exp=0", obs);
        end
        @(negedge clk);
        reset_n = 1'b1;
        drive(0, 1);
        @(negedge clk);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL reset_release cyc=%0d got=%h exp=%h", m_cyc, obs, exp);
        end
    endtask

    task automatic test_back_to_back();
        drive(0, 0);
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL back_to_back cyc=%0d got=%h exp=%h", m_cyc, obs, exp);
            end
            drive(c < 4, 1);
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done got=%b%b exp=10", done, busy);
        end
        drive(0, 0);
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done_fall got=%b exp=0", done);
        end
    endtask

    task automatic test_overflow_drain();
        drive(0, 0);
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL overflow_drain cyc=%0d got=%h exp=%h", m_cyc, obs, exp);
            end
            drive((c < 4) || (c == 5), 1);
        end
        checks++;
        if (overflow !== 1'b1 || done !== 1'b1) begin
            errors++;
            $display("FAIL overflow_set got=%b%b exp=11", overflow, done);
        end
        drive(0, 0);
        @(negedge clk);
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL overflow_clear got=%b exp=0", overflow);
        end
    endtask

    task automatic test_flush_feed();
        for (int c = 0; c < 3; c++) begin
            drive(c < 2, 1);
            @(negedge clk);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL flush_pre cyc=%0d got=%h exp=%h", m_cyc, obs, exp);
            end
        end
        drive(1, 0);
        @(negedge clk);
        checks++;
        if (out_valid !== '0 || busy !== 1'b0 || obs !== exp) begin
            errors++;
            $display("FAIL flush_feed got=%h exp=%h", obs, exp);
        end
        for (int c = 0; c < 13; c++) begin
            drive((c % 2) == 0 && c < 8, 1);
            @(negedge clk);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL flush_refill cyc=%0d got=%h exp=%h", m_cyc, obs, exp);
            end
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL flush_refill_done got=%b exp=1", done);
        end
    endtask

    task automatic test_random();
        bit en;
        for (int c = 0; c < 400; c++) begin
            en = ($urandom_range(0, 29) != 0) && !(exp_done && $urandom_range(0, 2) == 0);
            drive(1'($urandom_range(0, 1)), en);
            @(negedge clk);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL random cyc=%0d got=%h exp=%h", m_cyc, obs, exp);
            end
        end
    endtask

    task automatic test_rows1();
        logic [BM-1:0][DW-1:0] row;
        b_enable   = 1'b1;
        b_in_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < BM; i++) row[i] = DW'($urandom);
        b_in_data  = row;
        b_in_valid = 1'b1;
        @(negedge clk);
        b_in_valid = 1'b0;
        b_in_data  = '1;
        checks++;
        if ({b_busy, b_done, b_out_valid} !== 4'b1001 || b_out_data[0] !== row[0]
            || b_out_data[1] !== '0) begin
            errors++;
            $display("FAIL rows1_edge_k got=%b%b%b d=%h exp=1001 d0=%h",
                     b_busy, b_done, b_out_valid, b_out_data, row[0]);
        end
        @(negedge clk);
        checks++;
        if ({b_busy, b_done, b_out_valid} !== 4'b1010 || b_out_data[1] !== row[1]
            || b_out_data[0] !== '0) begin
            errors++;
            $display("FAIL rows1_edge_k1 got=%b%b%b d=%h exp=1010 d1=%h",
                     b_busy, b_done, b_out_valid, b_out_data, row[1]);
        end
        @(negedge clk);
        checks++;
        if ({b_busy, b_done, b_out_valid, b_overflow} !== 5'b01000) begin
            errors++;
            $display("FAIL rows1_done got=%b%b%b%b exp=01000",
                     b_busy, b_done, b_out_valid, b_overflow);
        end
        b_enable = 1'b0;
        @(negedge clk);
        checks++;
        if (b_done !== 1'b0) begin
            errors++;
            $display("FAIL rows1_done_fall got=%b exp=0", b_done);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_overflow_drain();
        test_flush_feed();
        test_random();
        test_rows1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
